// File: rtl/acc_seq_ctrl_pkg.sv
// Shared types and defaults for the convolution accumulator sequencing controller.
package acc_seq_ctrl_pkg;

    localparam int ACC_W        = 16;
    localparam int TAPS_DEF     = 25;
    localparam int NUM_OUTS_DEF = 784;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Negative results clamp to zero; the sign bit is the MSB of the two's complement sum.
    function automatic logic [ACC_W-1:0] relu(input logic [ACC_W-1:0] v);
        return v[ACC_W-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/acc_tap_counter.sv
// Wrapping event counter: counts inc pulses 0..TERM-1, then wraps to 0; clr has priority.
// Latency: count updates on the edge after inc; last is combinational from the count.
// Backpressure: none, the caller gates inc.
module acc_tap_counter #(
    parameter int W    = 8,
    parameter int TERM = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign cnt  = cnt_q;
    assign last = (cnt_q == W'(TERM - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = last ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Drives accumulator enable/clear over TAPS partial sums per output and writes NUM_OUTS results.
// Latency: result is on the write port the cycle after the last tap; ACC_SEQ_CTRL_RELU_EN adds ReLU.
// Backpressure: in_ready drops while a write waits; the write holds stable until wr_ready.
module acc_seq_ctrl
    import acc_seq_ctrl_pkg::*;
#(
    parameter int TAPS     = TAPS_DEF,
    parameter int NUM_OUTS = NUM_OUTS_DEF,
    parameter int ADDR_W   = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    acc_enable,
    output logic                    acc_clear,
    input  logic signed [ACC_W-1:0] acc_sum,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [ACC_W-1:0]        wr_data,
    output logic                    busy,
    output logic                    done
);

    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [7:0]          tap_cnt;
    logic                tap_last;
    logic [ADDR_W-1:0]   out_cnt_unused;
    logic                out_last;
    logic                job_start;
    logic                wr_hs;
    logic [ACC_W-1:0]    result;

    assign job_start  = (state_q == ST_IDLE) && start;
    assign in_ready   = (state_q == ST_ACCUM);
    assign acc_enable = in_valid && in_ready;
    assign acc_clear  = acc_enable && (tap_cnt == '0);
    assign wr_valid   = (state_q == ST_WRITE);
    assign wr_hs      = wr_valid && wr_ready;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

`ifdef ACC_SEQ_CTRL_RELU_EN
    assign result = relu(acc_sum);
`else
    assign result = acc_sum;
`endif

    // Outside WRITE the port reads zero so idle/reset values do not leak acc_sum or a stale address.
    assign wr_addr = wr_valid ? addr_q : '0;
    assign wr_data = wr_valid ? result : '0;

    acc_tap_counter #(
        .W    (8),
        .TERM (TAPS)
    ) u_tap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (job_start),
        .inc   (acc_enable),
        .cnt   (tap_cnt),
        .last  (tap_last)
    );

    acc_tap_counter #(
        .W    (ADDR_W),
        .TERM (NUM_OUTS)
    ) u_out_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (job_start),
        .inc   (wr_hs),
        .cnt   (out_cnt_unused),
        .last  (out_last)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCUM;
                    addr_d  = base_addr;
                end
            end
            ST_ACCUM: begin
                if (acc_enable && tap_last) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wr_ready) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = out_last ? ST_DONE : ST_ACCUM;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed bench for acc_seq_ctrl with a behavioural accumulator feeding acc_sum.
module tb_acc_seq_ctrl;

    localparam int TAPS  = 25;
    localparam int NOUTS = 2;
    localparam int AW    = 10;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic                 in_valid;
    logic                 in_ready;
    logic                 acc_enable;
    logic                 acc_clear;
    logic signed [15:0]   acc_q;
    logic signed [15:0]   psum;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [AW-1:0]        wr_addr;
    logic [15:0]          wr_data;
    logic                 busy;
    logic                 done;

    acc_seq_ctrl #(.TAPS(TAPS), .NUM_OUTS(NOUTS), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .acc_enable (acc_enable),
        .acc_clear  (acc_clear),
        .acc_sum    (acc_q),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External accumulator: clear loads the partial sum, otherwise it adds.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          acc_q <= '0;
        else if (acc_enable) acc_q <= acc_clear ? psum : acc_q + psum;
    end

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc_n, tap_idx, mode, done_cyc, wr_cnt;
    int en_bad, clr_cnt, rdy_bad, stab_bad, stall_obs, low_left;
    logic first_ok, hold_vld;
    logic [AW-1:0] hold_a;
    logic [15:0]   hold_d;
    logic [AW-1:0] wr_a [8];
    logic [15:0]   wr_d [8];

    task automatic clear_stats();
        done_cyc = -1; wr_cnt = 0; en_bad = 0; clr_cnt = 0; rdy_bad = 0;
        stab_bad = 0; stall_obs = 0; first_ok = 1'b0; hold_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_a[i] = '1;
            wr_d[i] = 16'hDEAD;
        end
    endtask

    task automatic tick(input logic v);
        @(negedge clk);
        start    = 1'b0;
        in_valid = v;
        wr_ready = (low_left > 0) ? 1'b0 : 1'b1;
        if (mode == 0) psum = 16'(tap_idx + 1);
        else           psum = (tap_idx == 0) ? 16'sd19 : -16'sd1;
        #1;
        if (cyc_n == 1) first_ok = busy && in_ready;
        if (acc_enable && !in_valid) en_bad++;
        if (acc_clear) clr_cnt++;
        if (wr_valid && in_ready) rdy_bad++;
        if (wr_valid) begin
            if (hold_vld && (wr_addr !== hold_a || wr_data !== hold_d)) stab_bad++;
            hold_a = wr_addr;
            hold_d = wr_data;
            hold_vld = !wr_ready;
            if (!wr_ready) begin
                stall_obs++;
                low_left--;
            end else begin
                if (wr_cnt < 8) begin
                    wr_a[wr_cnt] = wr_addr;
                    wr_d[wr_cnt] = wr_data;
                end
                wr_cnt++;
            end
        end else if (hold_vld) begin
            stab_bad++;
            hold_vld = 1'b0;
        end
        if (done && done_cyc < 0) done_cyc = cyc_n;
        if (acc_enable) tap_idx = (tap_idx == TAPS - 1) ? 0 : tap_idx + 1;
        cyc_n++;
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        @(negedge clk);
        start = 1'b1; base_addr = b; in_valid = 1'b0; wr_ready = 1'b1;
        tap_idx = 0; cyc_n = 1;
    endtask

    task automatic run_job(input logic [AW-1:0] b, input logic alt, input int low);
        clear_stats();
        low_left = low;
        do_start(b);
        for (int i = 0; i < 400 && done_cyc < 0; i++) tick(alt ? (cyc_n % 2 == 1) : 1'b1);
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; wr_ready = 1'b1;
        base_addr = 10'd77; psum = 16'sd3; mode = 0; low_left = 0;
        #2;
        tot_cnt++;
        if ({in_ready, acc_enable, acc_clear, wr_valid, busy, done} !== 6'b0)
            $display("FAIL reset_ctl got=%b exp=000000", {in_ready, acc_enable, acc_clear, wr_valid, busy, done});
        else pass_cnt++;
        tot_cnt++;
        if (wr_addr !== 10'd0) $display("FAIL reset_addr got=%0d exp=0", wr_addr); else pass_cnt++;
        @(posedge clk); #1;
        tot_cnt++;
        if (wr_data !== 16'd0 || busy !== 1'b0) $display("FAIL reset_hold data=%0d busy=%b exp 0/0", wr_data, busy);
        else pass_cnt++;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_basic();
        mode = 0;
        run_job(10'd0, 1'b0, 0);
        tot_cnt++; if (first_ok !== 1'b1) $display("FAIL basic_busy_e1 got=%b exp=1", first_ok); else pass_cnt++;
        tot_cnt++; if (done_cyc !== 53) $display("FAIL basic_done_cycle got=%0d exp=53", done_cyc); else pass_cnt++;
        tot_cnt++; if (wr_cnt !== 2) $display("FAIL basic_wr_cnt got=%0d exp=2", wr_cnt); else pass_cnt++;
        tot_cnt++; if (wr_a[0] !== 10'd0 || wr_d[0] !== 16'd325)
            $display("FAIL basic_wr0 got=(%0d,%0d) exp=(0,325)", wr_a[0], wr_d[0]); else pass_cnt++;
        tot_cnt++; if (wr_a[1] !== 10'd1 || wr_d[1] !== 16'd325)
            $display("FAIL basic_wr1 got=(%0d,%0d) exp=(1,325)", wr_a[1], wr_d[1]); else pass_cnt++;
        tot_cnt++; if (clr_cnt !== 2) $display("FAIL basic_clr_cnt got=%0d exp=2", clr_cnt); else pass_cnt++;
        tot_cnt++; if (busy !== 1'b0) $display("FAIL basic_idle_after got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_input_stall();
        mode = 0;
        run_job(10'd0, 1'b1, 0);
        tot_cnt++; if (wr_cnt !== 2) $display("FAIL stall_wr_cnt got=%0d exp=2", wr_cnt); else pass_cnt++;
        tot_cnt++; if (wr_a[0] !== 10'd0 || wr_d[0] !== 16'd325)
            $display("FAIL stall_wr0 got=(%0d,%0d) exp=(0,325)", wr_a[0], wr_d[0]); else pass_cnt++;
        tot_cnt++; if (wr_a[1] !== 10'd1 || wr_d[1] !== 16'd325)
            $display("FAIL stall_wr1 got=(%0d,%0d) exp=(1,325)", wr_a[1], wr_d[1]); else pass_cnt++;
        tot_cnt++; if (en_bad !== 0) $display("FAIL stall_enable_no_valid got=%0d exp=0", en_bad); else pass_cnt++;
        tot_cnt++; if (clr_cnt !== 2) $display("FAIL stall_clr_cnt got=%0d exp=2", clr_cnt); else pass_cnt++;
    endtask

    task automatic test_wr_backpressure();
        mode = 0;
        run_job(10'd0, 1'b0, 7);
        tot_cnt++; if (stall_obs !== 7) $display("FAIL bp_stall_cycles got=%0d exp=7", stall_obs); else pass_cnt++;
        tot_cnt++; if (stab_bad !== 0) $display("FAIL bp_stable got=%0d exp=0", stab_bad); else pass_cnt++;
        tot_cnt++; if (rdy_bad !== 0) $display("FAIL bp_in_ready_low got=%0d exp=0", rdy_bad); else pass_cnt++;
        tot_cnt++; if (wr_cnt !== 2) $display("FAIL bp_wr_cnt got=%0d exp=2", wr_cnt); else pass_cnt++;
        tot_cnt++; if (wr_a[0] !== 10'd0 || wr_d[0] !== 16'd325)
            $display("FAIL bp_wr0 got=(%0d,%0d) exp=(0,325)", wr_a[0], wr_d[0]); else pass_cnt++;
        tot_cnt++; if (done_cyc !== 60) $display("FAIL bp_done_cycle got=%0d exp=60", done_cyc); else pass_cnt++;
    endtask

    task automatic test_addr_wrap();
        mode = 0;
        run_job(10'd1023, 1'b0, 0);
        tot_cnt++; if (wr_a[0] !== 10'd1023) $display("FAIL wrap_addr0 got=%0d exp=1023", wr_a[0]); else pass_cnt++;
        tot_cnt++; if (wr_a[1] !== 10'd0) $display("FAIL wrap_addr1 got=%0d exp=0", wr_a[1]); else pass_cnt++;
    endtask

    task automatic test_negative();
        logic [15:0] exp_d;
`ifdef ACC_SEQ_CTRL_RELU_EN
        exp_d = 16'h0000;
`else
        exp_d = 16'hFFFB;
`endif
        mode = 1;
        run_job(10'd4, 1'b0, 0);
        tot_cnt++; if (wr_d[0] !== exp_d) $display("FAIL neg_wr0 got=%h exp=%h", wr_d[0], exp_d); else pass_cnt++;
        tot_cnt++; if (wr_d[1] !== exp_d) $display("FAIL neg_wr1 got=%h exp=%h", wr_d[1], exp_d); else pass_cnt++;
        mode = 0;
    endtask

    task automatic test_reset_mid();
        mode = 0;
        clear_stats();
        low_left = 0;
        do_start(10'd5);
        for (int i = 0; i < 11; i++) tick(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tot_cnt++;
        if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL rstmid_idle busy=%b in_ready=%b exp 0/0", busy, in_ready);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) tick(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1);
        tot_cnt++; if (wr_cnt !== 0) $display("FAIL rstmid_no_write got=%0d exp=0", wr_cnt); else pass_cnt++;
        run_job(10'd5, 1'b0, 0);
        tot_cnt++; if (wr_a[0] !== 10'd5 || wr_d[0] !== 16'd325)
            $display("FAIL rstmid_restart got=(%0d,%0d) exp=(5,325)", wr_a[0], wr_d[0]); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_input_stall();
        test_wr_backpressure();
        test_addr_wrap();
        test_negative();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/acc_seq_ctrl.md
# acc_seq_ctrl

Sequencing controller for the 16-bit convolution accumulator. It accepts a stream of multiplier-adder partial sums and drives the accumulator's `enable`/`clear` so that every `TAPS` accepted partial sums form one output. It then presents the finished sum on a write port with valid/ready backpressure and an auto-incrementing address. One job covers `NUM_OUTS` outputs, started by `start` and closed by a one-cycle `done`.

## Interface
- `TAPS`, default 25: partial sums per output; legal range 1..255.
- `NUM_OUTS`, default 784: outputs per job; legal range 1..2^ADDR_W.
- `ADDR_W`, default 10: write-address width.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: job start pulse; only sampled in IDLE.
- `base_addr` in ADDR_W: first write address; latched when `start` is accepted.
- `in_valid` in 1: multiplier-adder partial sum present this cycle.
- `in_ready` out 1: controller can take a partial sum.
- `acc_enable` out 1: drives the accumulator `enable`; equals `in_valid & in_ready`.
- `acc_clear` out 1: drives the accumulator `clear`; high on the first tap of each output.
- `acc_sum` in 16: accumulator `sum` output, signed two's complement.
- `wr_valid` out 1: result available for write.
- `wr_ready` in 1: consumer accepts the write.
- `wr_addr` out ADDR_W: result address.
- `wr_data` out 16: result value.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when the job completes.

## Operation
- States: IDLE, ACCUM, WRITE, DONE.
- IDLE:
  - `start=1` latches `base_addr` into `addr_q`, zeroes `tap_cnt` and `out_cnt`, and moves to ACCUM.
  - `start` outside IDLE is ignored.
- ACCUM:
  - `in_ready=1`.
  - Each handshake (`in_valid & in_ready`) increments `tap_cnt`.
  - `acc_clear = (tap_cnt==0) & acc_enable`, so the first tap loads the accumulator instead of adding.
  - On the handshake with `tap_cnt==TAPS-1`: `tap_cnt` returns to 0 and the state moves to WRITE.
  - Cycles with `in_valid=0` are stalls; counters and the accumulator hold.
- WRITE:
  - `in_ready=0` and `acc_enable=0`, so `acc_sum` is stable.
  - `wr_valid=1`, `wr_addr=addr_q`, `wr_data=f(acc_sum)`, where f is set by the Configuration macro.
  - On `wr_valid & wr_ready`: `addr_q` increments and `out_cnt` increments.
  - If `out_cnt==NUM_OUTS-1` the state moves to DONE; otherwise it moves back to ACCUM.
- DONE: `done=1` for one cycle, then the state moves to IDLE.
- `addr_q` increments modulo 2^ADDR_W, so wrap-around from all-ones to 0 is legal and silent.
- `TAPS=1`: every handshake both clears and completes an output; the state goes ACCUM→WRITE after each tap.
- `rst_n` asserted mid-job forces IDLE immediately. All counters clear and every output returns to its reset value. The in-flight output is discarded and no write is issued.

## Timing
- Reset values:
  - `in_ready`, `acc_enable`, `acc_clear`, `wr_valid`, `busy`, `done` = 0.
  - `wr_addr` and `wr_data` = 0.
  - State = IDLE.
- `start` is sampled at edge E; `busy` and `in_ready` are high from cycle E+1.
- Last tap handshake occurs in cycle N. The accumulator registers at the end of N, and `wr_valid` with a valid `wr_data` is high in cycle N+1.
- With `wr_ready` held high, each output takes exactly TAPS+1 cycles, giving a zero-stall job length of NUM_OUTS·(TAPS+1)+1 cycles from `start` to `done`.
- `wr_valid`, `wr_addr` and `wr_data` hold stable until `wr_ready`; `wr_valid` never drops without a handshake.
- `in_ready` is combinational from state only. It has no dependence on `in_valid`.

## Configuration
- Macro: `ACC_SEQ_CTRL_RELU_EN`.
- Defined: `wr_data = acc_sum[15] ? 16'd0 : acc_sum` (ReLU on the written result). This adds combinational logic only; latency is unchanged.
- Undefined: `wr_data = acc_sum` passthrough.

## Structure
- `acc_seq_ctrl_pkg` holds:
  - the state enum (IDLE, ACCUM, WRITE, DONE);
  - constants `ACC_W=16` and the `TAPS`/`NUM_OUTS` defaults.
- One natural sub-module: `acc_tap_counter`. It is a parameterised counter with `inc` and `clr`, wraps at a terminal count, and emits a `last` flag. Two instances are used, one for taps and one for outputs.

## Test plan
- TAPS=25, NUM_OUTS=2, base_addr=0, `in_valid` and `wr_ready` tied high, partial sums 1..25 per output:
  - writes (0,325) and (1,325);
  - `done` asserts exactly 53 cycles after `start`.
- `in_valid` deasserted every other cycle:
  - same sums and addresses as the previous scenario;
  - `acc_enable` is never high while `in_valid=0`;
  - `acc_clear` pulses exactly once per output.
- `wr_ready` held low for 7 cycles in WRITE:
  - `wr_valid`, `wr_addr` and `wr_data` are stable for all 7 cycles;
  - `in_ready=0` throughout;
  - exactly one write is issued.
- base_addr=1023, ADDR_W=10, NUM_OUTS=2: write addresses are 1023 then 0.
- Partial sums producing a total of −5, run twice:
  - with `ACC_SEQ_CTRL_RELU_EN` defined, `wr_data=0`;
  - without it, `wr_data=16'hFFFB`.
- `rst_n` pulsed low mid-ACCUM (tap 12 of output 0), then restarted:
  - no write is issued before the restart;
  - the first write lands at `base_addr` with the correct 25-tap sum.
